// File: rtl/hs_dpath_pipe_ctrl.sv
// Valid/ready flow controller for a CE-gated LATENCY-stage datapath pipeline.
// Tracks per-stage occupancy, drives stage clock enables, sequences drain and flush.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, upstream accepted when stage 0 can move
// ST_DRAIN | upstream blocked, pipeline empties under m_ready
// ST_FLUSH | single cycle, all enables off, valid bits cleared at end
module hs_dpath_pipe_ctrl #(
  parameter  int LATENCY = 3,
  localparam int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             ce_stage  [LATENCY],
  output logic             vld_stage [LATENCY],
  output logic [CNT_W-1:0] occupancy,
  input  logic             drain_req,
  output logic             drain_done,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state;
  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] go;
  logic [LATENCY-1:0] in_vld;
  logic [LATENCY-1:0] v_nxt;
  logic               run;
  logic               flushing;
  logic               accept;
  logic               retire;

  assign run      = (state == ST_RUN);
  assign flushing = (state == ST_FLUSH);

  // Stage i may advance when downstream is ready or any stage from i onward is empty;
  // written without a ripple through go[] so there is no combinational self-loop.
  always_comb begin
    go = '0;
    for (int i = 0; i < LATENCY; i++) begin
      go[i] = m_ready;
      for (int j = i; j < LATENCY; j++) begin
        if (!v[j]) go[i] = 1'b1;
      end
    end
  end

  assign s_ready = go[0] && run;
  assign accept  = s_valid && s_ready;
  assign m_valid = v[LATENCY-1] && !flushing;
  assign retire  = m_valid && m_ready;

  always_comb begin
    in_vld    = '0;
    in_vld[0] = accept;
    for (int i = 1; i < LATENCY; i++) begin
      in_vld[i] = v[i-1];
    end
  end

  always_comb begin
    v_nxt = v;
    for (int i = 0; i < LATENCY; i++) begin
      ce_stage[i]  = go[i] && in_vld[i] && !flushing;
      vld_stage[i] = v[i];
      if (go[i]) v_nxt[i] = in_vld[i];
    end
  end

  assign drain_done = (state == ST_DRAIN) && (occupancy == '0) && !flush_req;
  assign flush_done = flushing;
  assign busy       = (occupancy != '0) || !run;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state     <= ST_RUN;
      v         <= '0;
      occupancy <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush_req)      state <= ST_FLUSH;
          else if (drain_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (flush_req)              state <= ST_FLUSH;
          else if (occupancy == '0)   state <= ST_RUN;
        end
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase

      if (flushing) begin
        v         <= '0;
        occupancy <= '0;
      end else begin
        v <= v_nxt;
        if (accept && !retire)      occupancy <= occupancy + CNT_W'(1);
        else if (retire && !accept) occupancy <= occupancy - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hs_dpath_pipe_ctrl.sv
// Self-checking bench for hs_dpath_pipe_ctrl: item-movement reference model,
// directed scenarios plus randomized traffic with drain/flush/reset.
module tb_hs_dpath_pipe_ctrl;
  localparam int L     = 3;
  localparam int CNT_W = $clog2(L + 1);

  logic             clk = 1'b0;
  logic             aresetn;
  logic             s_valid, s_ready, m_valid, m_ready;
  logic             ce_stage  [L];
  logic             vld_stage [L];
  logic [CNT_W-1:0] occupancy;
  logic             drain_req, drain_done, flush_req, flush_done, busy;

  hs_dpath_pipe_ctrl #(.LATENCY(L)) dut (
    .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .ce_stage(ce_stage), .vld_stage(vld_stage),
    .occupancy(occupancy), .drain_req(drain_req), .drain_done(drain_done),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each slot holds an item id (0 = empty); mode 0 run, 1 drain, 2 flush.
  int slot [L];
  int mode;
  int next_id;
  bit mdl_ok = 0;
  int n_mvalid, n_ce0, n_drain_done, n_flush_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle();
    int nxt [L];
    logic [L-1:0] ce_e, ce_a, vld_e, vld_a;
    int cnt;
    bit run, exp_sr, exp_mv, acc, ret, exp_dd;
    #1;
    if (mdl_ok) begin
      cnt = 0;
      for (int i = 0; i < L; i++) if (slot[i] != 0) cnt++;
      run    = (mode == 0);
      exp_sr = run && (cnt < L || m_ready);
      acc    = s_valid && exp_sr;
      exp_mv = (slot[L-1] != 0) && (mode != 2);
      ret    = exp_mv && m_ready;
      exp_dd = (mode == 1) && (cnt == 0) && !flush_req;
      ce_e   = '0;
      for (int i = 0; i < L; i++) nxt[i] = slot[i];
      if (mode != 2) begin
        if (ret) nxt[L-1] = 0;
        for (int i = L - 2; i >= 0; i--) begin
          if (nxt[i] != 0 && nxt[i+1] == 0) begin
            nxt[i+1]  = nxt[i];
            nxt[i]    = 0;
            ce_e[i+1] = 1'b1;
          end
        end
        if (acc) begin
          if (nxt[0] != 0) begin
            errors++;
            $display("FAIL model_stage0_free at %0t: got busy expected empty", $time);
          end
          nxt[0]  = next_id;
          next_id++;
          ce_e[0] = 1'b1;
        end
      end else begin
        for (int i = 0; i < L; i++) nxt[i] = 0;
      end
      for (int i = 0; i < L; i++) begin
        ce_a[i]  = ce_stage[i];
        vld_a[i] = vld_stage[i];
        vld_e[i] = (slot[i] != 0);
      end
      chk("s_ready",    32'(s_ready),    32'(exp_sr));
      chk("m_valid",    32'(m_valid),    32'(exp_mv));
      chk("occupancy",  32'(occupancy),  32'(cnt));
      chk("vld_stage",  32'(vld_a),      32'(vld_e));
      chk("ce_stage",   32'(ce_a),       32'(ce_e));
      chk("drain_done", 32'(drain_done), 32'(exp_dd));
      chk("flush_done", 32'(flush_done), 32'(mode == 2));
      chk("busy",       32'(busy),       32'((cnt != 0) || !run));
      if (m_valid === 1'b1)     n_mvalid++;
      if (ce_stage[0] === 1'b1) n_ce0++;
      if (drain_done === 1'b1)  n_drain_done++;
      if (flush_done === 1'b1)  n_flush_done++;
    end
    @(posedge clk);
    if (!aresetn) begin
      for (int i = 0; i < L; i++) slot[i] = 0;
      mode   = 0;
      mdl_ok = 1;
    end else if (mdl_ok) begin
      for (int i = 0; i < L; i++) slot[i] = nxt[i];
      case (mode)
        0: mode = flush_req ? 2 : (drain_req ? 1 : 0);
        1: mode = flush_req ? 2 : (cnt == 0 ? 0 : 1);
        default: mode = 0;
      endcase
    end
    @(negedge clk);
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < L; i++) if (slot[i] != 0) c++;
    return c;
  endfunction

  task automatic idle_inputs();
    s_valid = 0; m_ready = 1; drain_req = 0; flush_req = 0; aresetn = 1;
  endtask

  task automatic test_reset();
    aresetn = 0; s_valid = 0; m_ready = 0; drain_req = 0; flush_req = 0;
    cycle(); cycle();
    idle_inputs();
    m_ready = 0;
    cycle();
    chk("reset_s_ready",   32'(s_ready),   32'd1);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_m_valid",   32'(m_valid),   32'd0);
  endtask

  task automatic test_stream();
    int mv0, ce0;
    idle_inputs();
    mv0 = n_mvalid; ce0 = n_ce0;
    s_valid = 1;
    for (int t = 0; t < 5; t++) cycle();
    s_valid = 0;
    for (int t = 0; t < 6; t++) cycle();
    chk("stream_m_valid_cycles", 32'(n_mvalid - mv0), 32'd5);
    chk("stream_ce0_cycles",     32'(n_ce0 - ce0),    32'd5);
  endtask

  task automatic test_backpressure();
    idle_inputs();
    s_valid = 1;
    for (int t = 0; t < 3; t++) cycle();
    m_ready = 0;
    for (int t = 0; t < 3; t++) cycle();
    chk("bp_occupancy_full", 32'(occupancy), 32'(L));
    chk("bp_s_ready_low",    32'(s_ready),   32'd0);
    m_ready = 1;
    for (int t = 0; t < 4; t++) cycle();
    s_valid = 0;
    for (int t = 0; t < 5; t++) cycle();
  endtask

  task automatic test_bubble();
    idle_inputs();
    s_valid = 1; cycle();
    s_valid = 0; m_ready = 0; cycle();
    s_valid = 1; cycle();
    s_valid = 0;
    for (int t = 0; t < 3; t++) cycle();
    chk("bubble_vld2", 32'(vld_stage[2]), 32'd1);
    chk("bubble_vld1", 32'(vld_stage[1]), 32'd1);
    chk("bubble_vld0", 32'(vld_stage[0]), 32'd0);
    m_ready = 1;
    for (int t = 0; t < 4; t++) cycle();
  endtask

  task automatic test_drain();
    int dd0, n;
    idle_inputs();
    m_ready = 0;
    s_valid = 1; cycle(); cycle();
    s_valid = 0;
    dd0 = n_drain_done;
    drain_req = 1; cycle();
    drain_req = 0; s_valid = 1;
    cycle(); cycle();
    m_ready = 1;
    n = 0;
    while (mode != 0 && n < 20) begin cycle(); n++; end
    chk("drain_timeout",    32'(n < 20),              32'd1);
    chk("drain_done_count", 32'(n_drain_done - dd0),  32'd1);
    cycle();
    s_valid = 0;
    for (int t = 0; t < 4; t++) cycle();
    dd0 = n_drain_done;
    drain_req = 1; cycle();
    drain_req = 0; cycle();
    chk("drain_empty_done", 32'(n_drain_done - dd0), 32'd1);
  endtask

  task automatic test_flush_with_drain();
    int dd0, fd0;
    idle_inputs();
    m_ready = 0; s_valid = 1;
    for (int t = 0; t < 3; t++) cycle();
    s_valid = 0;
    dd0 = n_drain_done; fd0 = n_flush_done;
    drain_req = 1; flush_req = 1; cycle();
    drain_req = 0; flush_req = 0; cycle();
    cycle();
    chk("flush_occupancy",  32'(occupancy),           32'd0);
    chk("flush_done_count", 32'(n_flush_done - fd0),  32'd1);
    chk("flush_no_drain",   32'(n_drain_done - dd0),  32'd0);
    m_ready = 1;
  endtask

  task automatic test_reset_mid_drain();
    int dd0;
    idle_inputs();
    m_ready = 0; s_valid = 1; cycle(); cycle();
    s_valid = 0;
    dd0 = n_drain_done;
    drain_req = 1; cycle();
    drain_req = 0; cycle();
    chk("rmd_in_drain", 32'(mode), 32'd1);
    aresetn = 0; cycle();
    aresetn = 1; cycle();
    chk("rmd_occupancy",  32'(occupancy),          32'd0);
    chk("rmd_s_ready",    32'(s_ready),            32'd1);
    chk("rmd_no_done",    32'(n_drain_done - dd0), 32'd0);
    m_ready = 1;
  endtask

  task automatic test_random();
    idle_inputs();
    for (int t = 0; t < 600; t++) begin
      s_valid   = 1'($urandom_range(0, 1));
      m_ready   = ($urandom_range(0, 3) != 0);
      drain_req = ($urandom_range(0, 19) == 0);
      flush_req = ($urandom_range(0, 39) == 0);
      aresetn   = ($urandom_range(0, 149) != 0);
      cycle();
    end
    idle_inputs();
    for (int t = 0; t < 6; t++) cycle();
    chk("random_final_occ", 32'(occupancy), 32'(model_cnt()));
  endtask

  initial begin
    for (int i = 0; i < L; i++) slot[i] = 0;
    mode = 0; next_id = 1;
    n_mvalid = 0; n_ce0 = 0; n_drain_done = 0; n_flush_done = 0;
    aresetn = 0; s_valid = 0; m_ready = 0; drain_req = 0; flush_req = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_drain();
    test_flush_with_drain();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hs_dpath_pipe_ctrl.md
Name: hs_dpath_pipe_ctrl

Overview:
Flow controller that sequences a LATENCY-deep, CE-gated datapath pipeline from a valid/ready handshake. It tracks one valid bit per stage and drives the per-stage clock enables, so bubbles collapse and back-pressure propagates. It also provides drain and flush sequencing for reconfiguration. It sits beside a CE-tapped shift-register datapath and replaces a free-running CE chain wherever back-pressure is needed.

Parameters:
LATENCY, 3, number of datapath register stages (1 or more); sets input-to-output latency.
CNT_W, $clog2(LATENCY+1), width of the occupancy count (derived; do not override).

Ports:
clk  input  1  system clock, rising edge
aresetn  input  1  synchronous, active-low reset
s_valid  input  1  upstream data valid
s_ready  output  1  upstream ready; accept = s_valid && s_ready
m_valid  output  1  downstream data valid (last stage occupied)
m_ready  input  1  downstream ready; retire = m_valid && m_ready
ce_stage  output  LATENCY (unpacked [LATENCY])  clock enable for datapath stage register i; stage 0 captures input data
vld_stage  output  LATENCY (unpacked [LATENCY])  per-stage occupancy bit v[i]
occupancy  output  CNT_W  number of valid stages
drain_req  input  1  level; request to stop accepting and empty the pipeline
drain_done  output  1  one-cycle pulse when drain completes
flush_req  input  1  level; request to discard all in-flight data
flush_done  output  1  one-cycle pulse when flush completes
busy  output  1  high when occupancy != 0 or state != RUN

Behaviour:
- Reset (clk edge with aresetn=0): state=RUN, all v[i]=0, occupancy=0. All outputs are 0 except s_ready, which is 1 combinationally once state is RUN.
- Advance chain (combinational): go[LATENCY]=m_ready; go[i] = !v[i] || go[i+1].
- Stage input valid: in[0] = accept; in[i] = v[i-1] for i>0.
- ce_stage[i] = go[i] && in[i] && (state != FLUSH).
- v[i] next = go[i] ? in[i] : v[i].
- Consequence: a stalled stage holds; an empty stage fills even when downstream is stalled.
- m_valid = v[LATENCY-1] && (state != FLUSH).
- s_ready = go[0] && (state == RUN).
- s_ready may depend combinationally on m_ready (intentional). No combinational path from s_valid to s_ready.
- Latency: with m_ready held high, accept at cycle t gives m_valid at t+LATENCY. Full throughput is 1 item per cycle.
- Occupancy updates each cycle: +1 on accept, -1 on retire, unchanged if both or neither occur. It always equals popcount(v) and never exceeds LATENCY.
- FSM states: RUN, DRAIN, FLUSH (state is registered).
- RUN:
  - flush_req -> FLUSH (flush has priority over drain).
  - else drain_req -> DRAIN.
- DRAIN:
  - s_ready=0; pipeline keeps advancing under m_ready.
  - When occupancy==0: drain_done=1 in that cycle, next state RUN.
  - flush_req -> FLUSH, overriding completion; drain_done is not asserted in that case.
  - Drain when already empty: DRAIN lasts exactly 1 cycle with drain_done=1.
- FLUSH (exactly 1 cycle):
  - s_ready=0, m_valid=0, all ce_stage=0, flush_done=1.
  - At the end of the cycle all v cleared and occupancy=0; next state RUN.
  - If flush_req is still high in the following RUN cycle, re-enter FLUSH (level-sensitive).
- drain_req held high after drain_done: re-enters DRAIN, then completes immediately on the following cycle, since the pipeline is empty.
- Reset asserted mid-operation aborts any drain or flush with no done pulse. Data registers are not cleared by this block; valid bits gate them.
- Datapath register reset values are owned by the datapath, not by this block.

Test Plan:
- LATENCY=3, m_ready=1: s_valid high for 5 cycles from t=0 -> s_ready=1 throughout; m_valid high t=3..7; occupancy reaches 3; ce_stage[0] high t=0..4.
- Back-pressure: fill 3 items, then m_ready=0 -> s_ready=0 once all v=1 and occupancy=3; all ce_stage=0. Set m_ready=1 -> one retire per cycle, s_ready=1 the same cycle.
- Bubble collapse: accept at t=0 and t=2, m_ready=0 from t=1 -> by t=5 vld_stage={1,1,0} (stage2, stage1 full) and occupancy=2; no ce asserted on the full stage 2.
- Drain: 2 items in flight, drain_req pulse -> s_ready=0 while draining; drain_done single pulse on the cycle occupancy=0; state back to RUN; then an accept succeeds.
- Flush with drain: occupancy=3, drain_req and flush_req asserted together -> FLUSH entered; m_valid=0 and flush_done=1 for 1 cycle; then occupancy=0 and no drain_done.
- Reset mid-drain: aresetn=0 for 1 cycle during DRAIN with occupancy=2 -> occupancy=0, m_valid=0, drain_done never pulses, s_ready=1 after reset.
